// File: rtl/control_sequencer.sv
// control_sequencer
//   Hardwired control unit for the CPU datapath. Each instruction is stepped through
//   T0..T6: fetch through PC/MAR/MDR, decode IR, then an ALU or MUL/DIV execute and
//   write-back. The strobes connect 1:1 to the datapath control inputs.
//
// Ports
//   clock      in   rising-edge clock
//   clear      in   synchronous active-high reset
//   ir         in   IR contents: op=[31:27], ra=[26:23], rb=[22:19], rc=[18:15]
//   mem_ready  in   memory read data valid this cycle
//   PCout .. Rin    out  datapath strobes
//   reg_sel    out  GP register index used with Rout/Rin
//   alu_op     out  ALU operation (the opcode) during T4, otherwise 0
//   run        out  1 while sequencing, 0 in RST and HALT
module control_sequencer #(
    parameter int unsigned     OPW     = 5,
    parameter int unsigned     RSW     = 4,
    parameter logic [OPW-1:0]  OP_ADD  = 5'b00011,
    parameter logic [OPW-1:0]  OP_SUB  = 5'b00100,
    parameter logic [OPW-1:0]  OP_AND  = 5'b00101,
    parameter logic [OPW-1:0]  OP_OR   = 5'b00110,
    parameter logic [OPW-1:0]  OP_MUL  = 5'b01111,
    parameter logic [OPW-1:0]  OP_DIV  = 5'b10000,
    parameter logic [OPW-1:0]  OP_HALT = 5'b11011
) (
    input  logic           clock,
    input  logic           clear,
    input  logic [31:0]    ir,
    input  logic           mem_ready,
    output logic           PCout,
    output logic           IncPC,
    output logic           PCin,
    output logic           MARin,
    output logic           Zin,
    output logic           Read,
    output logic           MDRin,
    output logic           MDRout,
    output logic           IRin,
    output logic           Yin,
    output logic           Zlowout,
    output logic           ZHighout,
    output logic           LOin,
    output logic           HIin,
    output logic           Rout,
    output logic           Rin,
    output logic [RSW-1:0] reg_sel,
    output logic [OPW-1:0] alu_op,
    output logic           run
);

    typedef enum logic [3:0] {
        StRst,
        StT0,
        StT1,
        StT2,
        StT3,
        StT4,
        StT5,
        StT6,
        StHalt
    } state_e;

    state_e state_q, state_d;
    // Set while T1 is being held for memory; suppresses the repeat PCin pulse.
    logic   t1_wait_q, t1_wait_d;

    logic [OPW-1:0] op;
    logic [RSW-1:0] ra, rb, rc;
    logic           is_alu, is_muldiv;

    assign op = ir[31 -: OPW];
    assign ra = ir[31-OPW -: RSW];
    assign rb = ir[31-OPW-RSW -: RSW];
    assign rc = ir[31-OPW-2*RSW -: RSW];

    logic unused_ir;
    assign unused_ir = ^ir[31-OPW-3*RSW:0];

    assign is_alu    = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= StRst;
            t1_wait_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            t1_wait_q <= t1_wait_d;
        end
    end

    // Next state
    always_comb begin
        state_d   = state_q;
        t1_wait_d = (state_q == StT1) && !mem_ready;
        unique case (state_q)
            StRst:  state_d = StT0;
            StT0:   state_d = StT1;
            StT1:   state_d = mem_ready ? StT2 : StT1;
            StT2:   state_d = StT3;
            StT3: begin
                if (op == OP_HALT)             state_d = StHalt;
                else if (is_alu || is_muldiv)  state_d = StT4;
                else                           state_d = StT0;
            end
            StT4:   state_d = StT5;
            StT5:   state_d = is_muldiv ? StT6 : StT0;
            StT6:   state_d = StT0;
            StHalt: state_d = StHalt;
            default: state_d = StRst;
        endcase
    end

    // Moore outputs: decode of state_q (and ir from T3 on)
    always_comb begin
        PCout    = 1'b0;
        IncPC    = 1'b0;
        PCin     = 1'b0;
        MARin    = 1'b0;
        Zin      = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zlowout  = 1'b0;
        ZHighout = 1'b0;
        LOin     = 1'b0;
        HIin     = 1'b0;
        Rout     = 1'b0;
        Rin      = 1'b0;
        reg_sel  = '0;
        alu_op   = '0;
        run      = 1'b0;
        unique case (state_q)
            StT0: begin
                run   = 1'b1;
                PCout = 1'b1;
                IncPC = 1'b1;
                MARin = 1'b1;
                Zin   = 1'b1;
            end
            StT1: begin
                run     = 1'b1;
                Zlowout = 1'b1;
                PCin    = !t1_wait_q;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            StT2: begin
                run    = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            StT3: begin
                run = 1'b1;
                if (op != OP_HALT && (is_alu || is_muldiv)) begin
                    Rout    = 1'b1;
                    reg_sel = rb;
                    Yin     = 1'b1;
                end
            end
            StT4: begin
                run     = 1'b1;
                Rout    = 1'b1;
                reg_sel = rc;
                alu_op  = op;
                Zin     = 1'b1;
            end
            StT5: begin
                run = 1'b1;
                if (is_alu) begin
                    Zlowout = 1'b1;
                    Rin     = 1'b1;
                    reg_sel = ra;
                end else if (is_muldiv) begin
                    Zlowout = 1'b1;
                    LOin    = 1'b1;
                end
            end
            StT6: begin
                run      = 1'b1;
                ZHighout = 1'b1;
                HIin     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    logic        clock;
    logic        clear;
    logic [31:0] ir;
    logic        mem_ready;
    logic        PCout, IncPC, PCin, MARin, Zin, Read, MDRin, MDRout, IRin, Yin;
    logic        Zlowout, ZHighout, LOin, HIin, Rout, Rin;
    logic [3:0]  reg_sel;
    logic [4:0]  alu_op;
    logic        run;

    control_sequencer dut (
        .clock    (clock),
        .clear    (clear),
        .ir       (ir),
        .mem_ready(mem_ready),
        .PCout    (PCout),
        .IncPC    (IncPC),
        .PCin     (PCin),
        .MARin    (MARin),
        .Zin      (Zin),
        .Read     (Read),
        .MDRin    (MDRin),
        .MDRout   (MDRout),
        .IRin     (IRin),
        .Yin      (Yin),
        .Zlowout  (Zlowout),
        .ZHighout (ZHighout),
        .LOin     (LOin),
        .HIin     (HIin),
        .Rout     (Rout),
        .Rin      (Rin),
        .reg_sel  (reg_sel),
        .alu_op   (alu_op),
        .run      (run)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Strobe bit masks, ordered PCout (MSB) .. Rin (LSB)
    localparam logic [15:0] S_PCOUT = 16'h8000, S_INCPC = 16'h4000, S_PCIN  = 16'h2000;
    localparam logic [15:0] S_MARIN = 16'h1000, S_ZIN   = 16'h0800, S_READ  = 16'h0400;
    localparam logic [15:0] S_MDRIN = 16'h0200, S_MDROUT = 16'h0100, S_IRIN = 16'h0080;
    localparam logic [15:0] S_YIN   = 16'h0040, S_ZLO   = 16'h0020, S_ZHI   = 16'h0010;
    localparam logic [15:0] S_LOIN  = 16'h0008, S_HIIN  = 16'h0004, S_ROUT  = 16'h0002;
    localparam logic [15:0] S_RIN   = 16'h0001;

    localparam logic [15:0] T0_S  = S_PCOUT | S_INCPC | S_MARIN | S_ZIN;
    localparam logic [15:0] T1_S  = S_ZLO | S_PCIN | S_READ | S_MDRIN;
    localparam logic [15:0] T1H_S = S_ZLO | S_READ | S_MDRIN;
    localparam logic [15:0] T2_S  = S_MDROUT | S_IRIN;

    localparam logic [31:0] I_AND  = 32'h2891_8000; // and r1,r2,r3
    localparam logic [31:0] I_MUL  = 32'h7822_8000; // mul r0,r4,r5
    localparam logic [31:0] I_NOP  = 32'hF800_0000; // opcode 11111
    localparam logic [31:0] I_ADD  = 32'h1891_8000; // add r1,r2,r3
    localparam logic [31:0] I_HALT = 32'hD800_0000;
    localparam logic [31:0] I_SUB  = 32'h2223_8000; // sub r4,r4,r7

    typedef struct {
        logic        clr;
        logic        mr;
        logic [31:0] ir;
        logic [15:0] strb;
        logic [3:0]  sel;
        logic [4:0]  op;
        logic        run;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic clr, input logic mr, input logic [31:0] i,
                       input logic [15:0] s, input logic [3:0] sel, input logic [4:0] op,
                       input logic r, input string n);
        vec_t v;
        v.clr = clr; v.mr = mr; v.ir = i; v.strb = s; v.sel = sel; v.op = op;
        v.run = r; v.name = n;
        vecs.push_back(v);
    endtask

    function automatic logic [15:0] strobes();
        return {PCout, IncPC, PCin, MARin, Zin, Read, MDRin, MDRout, IRin, Yin,
                Zlowout, ZHighout, LOin, HIin, Rout, Rin};
    endfunction

    initial begin
        // Reset, then an AND fetch/execute with zero wait states
        add(1, 1, I_AND, 16'h0, 0, 0, 0, "rst_a");
        add(0, 1, I_AND, 16'h0, 0, 0, 0, "rst_b");
        add(0, 1, I_AND, T0_S, 0, 0, 1, "and_t0");
        add(0, 1, I_AND, T1_S, 0, 0, 1, "and_t1");
        add(0, 1, I_AND, T2_S, 0, 0, 1, "and_t2");
        add(0, 1, I_AND, S_ROUT | S_YIN, 2, 0, 1, "and_t3");
        add(0, 1, I_AND, S_ROUT | S_ZIN, 3, 5'b00101, 1, "and_t4");
        add(0, 1, I_AND, S_ZLO | S_RIN, 1, 0, 1, "and_t5");
        // Next fetch; memory stalls three cycles in T1
        add(0, 1, I_AND, T0_S, 0, 0, 1, "mul_t0");
        add(0, 0, I_AND, T1_S, 0, 0, 1, "wait_t1a");
        add(0, 0, I_AND, T1H_S, 0, 0, 1, "wait_t1b");
        add(0, 0, I_AND, T1H_S, 0, 0, 1, "wait_t1c");
        add(0, 1, I_AND, T1H_S, 0, 0, 1, "wait_t1d");
        add(0, 1, I_MUL, T2_S, 0, 0, 1, "mul_t2");
        add(0, 1, I_MUL, S_ROUT | S_YIN, 4, 0, 1, "mul_t3");
        add(0, 1, I_MUL, S_ROUT | S_ZIN, 5, 5'b01111, 1, "mul_t4");
        add(0, 1, I_MUL, S_ZLO | S_LOIN, 0, 0, 1, "mul_t5");
        add(0, 1, I_MUL, S_ZHI | S_HIIN, 0, 0, 1, "mul_t6");
        // Undefined opcode is a NOP
        add(0, 1, I_MUL, T0_S, 0, 0, 1, "nop_t0");
        add(0, 1, I_MUL, T1_S, 0, 0, 1, "nop_t1");
        add(0, 1, I_NOP, T2_S, 0, 0, 1, "nop_t2");
        add(0, 1, I_NOP, 16'h0, 0, 0, 1, "nop_t3");
        // ADD aborted by clear in T4
        add(0, 1, I_NOP, T0_S, 0, 0, 1, "add_t0");
        add(0, 1, I_NOP, T1_S, 0, 0, 1, "add_t1");
        add(0, 1, I_ADD, T2_S, 0, 0, 1, "add_t2");
        add(0, 1, I_ADD, S_ROUT | S_YIN, 2, 0, 1, "add_t3");
        add(1, 1, I_ADD, S_ROUT | S_ZIN, 3, 5'b00011, 1, "add_t4_clr");
        add(0, 1, I_ADD, 16'h0, 0, 0, 0, "abort_rst");
        // Refetch: HALT
        add(0, 1, I_ADD, T0_S, 0, 0, 1, "halt_t0");
        add(0, 1, I_ADD, T1_S, 0, 0, 1, "halt_t1");
        add(0, 1, I_HALT, T2_S, 0, 0, 1, "halt_t2");
        add(0, 1, I_HALT, 16'h0, 0, 0, 1, "halt_t3");
        for (int k = 0; k < 9; k++) add(0, 1, I_HALT, 16'h0, 0, 0, 0, "halted");
        add(1, 1, I_HALT, 16'h0, 0, 0, 0, "halted_clr");
        // Recover; SUB with ra == rb
        add(0, 1, I_HALT, 16'h0, 0, 0, 0, "rec_rst");
        add(0, 1, I_HALT, T0_S, 0, 0, 1, "sub_t0");
        add(0, 1, I_HALT, T1_S, 0, 0, 1, "sub_t1");
        add(0, 1, I_SUB, T2_S, 0, 0, 1, "sub_t2");
        add(0, 1, I_SUB, S_ROUT | S_YIN, 4, 0, 1, "sub_t3");
        add(0, 1, I_SUB, S_ROUT | S_ZIN, 7, 5'b00100, 1, "sub_t4");
        add(0, 1, I_SUB, S_ZLO | S_RIN, 4, 0, 1, "sub_t5");
        add(0, 1, I_SUB, T0_S, 0, 0, 1, "sub_next_t0");

        clear     = 1'b1;
        mem_ready = 1'b1;
        ir        = 32'h0;
        @(posedge clock);
        #1;
        foreach (vecs[n]) begin
            clear     = vecs[n].clr;
            mem_ready = vecs[n].mr;
            ir        = vecs[n].ir;
            #1;
            total++;
            if ({strobes(), reg_sel, alu_op, run} !==
                {vecs[n].strb, vecs[n].sel, vecs[n].op, vecs[n].run}) begin
                bad++;
                $display("FAIL %s (vec %0d): got strb=%h sel=%0d op=%b run=%b, want strb=%h sel=%0d op=%b run=%b",
                         vecs[n].name, n, strobes(), reg_sel, alu_op, run,
                         vecs[n].strb, vecs[n].sel, vecs[n].op, vecs[n].run);
            end
            total++;
            if (Rin && Rout) begin
                bad++;
                $display("FAIL rin_rout_excl (vec %0d): got both 1, want not both", n);
            end
            @(posedge clock);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
